// File: rtl/lock_pkg.sv
// Shared definitions for the door-lock password handshake: state encodings,
// code length and the reference password.
package lock_pkg;

    localparam int PASS_LEN = 4;
    localparam int DIGIT_CW = 3;

    // Reference code for keys 1,0,1,0; bit 0 holds the first key entered.
    localparam logic [PASS_LEN-1:0] DEFAULT_PASS = 4'b0101;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_REQ   = 4'd1,
        S_CONF1 = 4'd2,
        S_CHECK = 4'd3,
        S_CONF2 = 4'd4,
        S_WAIT  = 4'd5,
        S_HOLD  = 4'd6,
        S_DENY  = 4'd7,
        S_REL   = 4'd8
    } state_t;

endpackage

// File: rtl/lock_cycle_timer.sv
// Saturating phase timer shared by the CHECK, WAIT and HOLD phases; last is
// high during the final cycle of a phase that lasts term cycles.
module lock_cycle_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] term,
    output logic          last
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // Widened by one bit so the compare stays correct at saturation.
    assign last = (({1'b0, count} + 1'b1) >= {1'b0, term});

endmodule

// File: rtl/pass_requester.sv
// Initiator side of the door-lock handshake: shifts in a 4-bit code, then walks
// request/confirm through the lock checker's sequence and waits for a grant.
module pass_requester
    import lock_pkg::*;
#(
    parameter int CHECK_CYCLES = 4,
    parameter int TIMEOUT      = 16,
    parameter int HOLD_CYCLES  = 8,
    parameter int CW           = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    input  logic                key_bit,
    input  logic                send,
    input  logic                abort,
    input  logic                en_left,
    input  logic                en_right,
    output logic                request,
    output logic                confirm,
    output logic [PASS_LEN-1:0] pass_data,
    output logic                busy,
    output logic                granted,
    output logic                side,
    output logic                denied
);

    localparam logic [CW-1:0] CHECK_T   = CW'(CHECK_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_T = CW'(TIMEOUT);
    localparam logic [CW-1:0] HOLD_T    = CW'(HOLD_CYCLES);

    state_t              state;
    state_t              next_state;
    logic [DIGIT_CW-1:0] digit_cnt;
    logic                have_code;
    logic                grant_in;
    logic                timer_clear;
    logic                timer_en;
    logic                timer_last;
    logic [CW-1:0]       timer_term;

    assign have_code = (digit_cnt == DIGIT_CW'(PASS_LEN));
    assign grant_in  = en_left | en_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (!abort && send && have_code) next_state = S_REQ;
            S_REQ:   next_state = S_CONF1;
            S_CONF1: next_state = S_CHECK;
            S_CHECK: if (timer_last) next_state = S_CONF2;
            S_CONF2: next_state = S_WAIT;
            // A grant arriving on the timeout cycle still wins.
            S_WAIT: begin
                if (grant_in) begin
                    next_state = S_HOLD;
                end else if (timer_last) begin
                    next_state = S_DENY;
                end
            end
            S_HOLD:  if (timer_last) next_state = S_REL;
            S_DENY:  next_state = S_REL;
            S_REL:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (abort && (state != S_IDLE) && (state != S_REL)) begin
            next_state = S_REL;
        end
    end

    // Every phase change restarts the timer, so each timed phase starts at 0.
    assign timer_clear = (next_state != state);
    assign timer_en    = (state == S_CHECK) || (state == S_WAIT) || (state == S_HOLD);

    always_comb begin
        case (state)
            S_CHECK: timer_term = CHECK_T;
            S_WAIT:  timer_term = TIMEOUT_T;
            default: timer_term = HOLD_T;
        endcase
    end

    lock_cycle_timer #(
        .CW(CW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_en),
        .term   (timer_term),
        .last   (timer_last)
    );

    // Outputs are registered decodes of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            request   <= 1'b0;
            confirm   <= 1'b0;
            busy      <= 1'b0;
            granted   <= 1'b0;
            denied    <= 1'b0;
            side      <= 1'b0;
            pass_data <= '0;
            digit_cnt <= '0;
        end else begin
            request <= next_state inside {S_REQ, S_CONF1, S_CHECK, S_CONF2, S_WAIT, S_HOLD};
            confirm <= (next_state == S_CONF1) || (next_state == S_CONF2);
            busy    <= (next_state != S_IDLE);
            granted <= (next_state == S_HOLD);
            denied  <= (next_state == S_DENY);
            if ((state == S_WAIT) && (next_state == S_HOLD)) begin
                side <= en_right;
            end
            if ((next_state == S_REL) || ((state == S_IDLE) && abort)) begin
                pass_data <= '0;
                digit_cnt <= '0;
            end else if ((state == S_IDLE) && key_valid && !have_code) begin
                pass_data[digit_cnt[1:0]] <= key_bit;
                digit_cnt                 <= digit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pass_requester.sv
// Directed bench for pass_requester: a cycle-by-cycle vector table for one full
// granted session, then hand-written sequences for the multi-cycle corners.
module tb_pass_requester;
    import lock_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_bit = 1'b0;
    logic       send = 1'b0;
    logic       abort = 1'b0;
    logic       en_left = 1'b0;
    logic       en_right = 1'b0;
    logic       request;
    logic       confirm;
    logic [3:0] pass_data;
    logic       busy;
    logic       granted;
    logic       side;
    logic       denied;

    int tests = 0;
    int fails = 0;

    // Input field order: {key_valid, key_bit, send, abort, en_left, en_right}
    // Output field order: {request, confirm, pass_data[3:0], busy, granted, side, denied}
    typedef struct {
        logic [5:0] in;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pass_requester dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_bit   (key_bit),
        .send      (send),
        .abort     (abort),
        .en_left   (en_left),
        .en_right  (en_right),
        .request   (request),
        .confirm   (confirm),
        .pass_data (pass_data),
        .busy      (busy),
        .granted   (granted),
        .side      (side),
        .denied    (denied)
    );

    function automatic logic [9:0] o(input logic req, input logic conf, input logic [3:0] pd,
                                     input logic bsy, input logic gr, input logic sd,
                                     input logic den);
        return {req, conf, pd, bsy, gr, sd, den};
    endfunction

    function automatic logic [9:0] outs();
        return {request, confirm, pass_data, busy, granted, side, denied};
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] in);
        {key_valid, key_bit, send, abort, en_left, en_right} = in;
        @(posedge clk);
        #1;
        {key_valid, key_bit, send, abort, en_left, en_right} = '0;
    endtask

    task automatic enter_code(input logic [3:0] code);
        for (int i = 0; i < 4; i++) begin
            step({1'b1, code[i], 4'b0000});
        end
    endtask

    // send, then 7 idle cycles: REQ, CONF1, CHECK x4, CONF2, landing in WAIT.
    task automatic to_wait();
        step(6'b001000);
        repeat (7) step(6'b000000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Keys 1,0,1,0, a surplus key, send, key during CHECK, en_left after two WAIT cycles.
        vecs.push_back('{6'b110000, o(0, 0, 4'b0001, 0, 0, 0, 0)});
        vecs.push_back('{6'b100000, o(0, 0, 4'b0001, 0, 0, 0, 0)});
        vecs.push_back('{6'b110000, o(0, 0, 4'b0101, 0, 0, 0, 0)});
        vecs.push_back('{6'b100000, o(0, 0, 4'b0101, 0, 0, 0, 0)});
        vecs.push_back('{6'b110000, o(0, 0, 4'b0101, 0, 0, 0, 0)});
        vecs.push_back('{6'b001000, o(1, 0, 4'b0101, 1, 0, 0, 0)});
        vecs.push_back('{6'b000000, o(1, 1, 4'b0101, 1, 0, 0, 0)});
        vecs.push_back('{6'b110000, o(1, 0, 4'b0101, 1, 0, 0, 0)});
        for (int i = 0; i < 3; i++) vecs.push_back('{6'b000000, o(1, 0, 4'b0101, 1, 0, 0, 0)});
        vecs.push_back('{6'b000000, o(1, 1, 4'b0101, 1, 0, 0, 0)});
        vecs.push_back('{6'b000000, o(1, 0, 4'b0101, 1, 0, 0, 0)});
        vecs.push_back('{6'b000000, o(1, 0, 4'b0101, 1, 0, 0, 0)});
        vecs.push_back('{6'b000010, o(1, 0, 4'b0101, 1, 1, 0, 0)});
        for (int i = 0; i < 7; i++) vecs.push_back('{6'b000000, o(1, 0, 4'b0101, 1, 1, 0, 0)});
        vecs.push_back('{6'b000000, o(0, 0, 4'b0000, 1, 0, 0, 0)});
        vecs.push_back('{6'b000000, o(0, 0, 4'b0000, 0, 0, 0, 0)});

        // Reset holds everything at zero even with activity on the inputs.
        {key_valid, key_bit, send, abort, en_left, en_right} = 6'b111011;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), '0);
        {key_valid, key_bit, send, abort, en_left, en_right} = '0;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].in);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Both grants together: right side wins.
        enter_code(DEFAULT_PASS);
        to_wait();
        chk("wait_entry", outs(), o(1, 0, DEFAULT_PASS, 1, 0, 0, 0));
        step(6'b000011);
        chk("both_grant", outs(), o(1, 0, DEFAULT_PASS, 1, 1, 1, 0));
        repeat (7) step(6'b000000);
        chk("both_hold_end", outs(), o(1, 0, DEFAULT_PASS, 1, 1, 1, 0));
        step(6'b000000);
        chk("both_release", outs(), o(0, 0, 4'b0000, 1, 0, 1, 0));
        step(6'b000000);
        chk("both_idle", outs(), o(0, 0, 4'b0000, 0, 0, 1, 0));

        // No grant: denied appears exactly 16 cycles after WAIT entry, request drops with it.
        enter_code(4'b1111);
        to_wait();
        chk("deny_code", {6'b0, pass_data}, {6'b0, 4'b1111});
        for (int k = 1; k <= 16; k++) begin
            step(6'b000000);
            chk($sformatf("deny_cyc%0d", k), {8'b0, denied, request},
                (k == 16) ? 10'b10 : 10'b01);
        end
        step(6'b000000);
        chk("deny_release", outs(), o(0, 0, 4'b0000, 1, 0, 1, 0));
        step(6'b000000);
        chk("deny_idle", {9'b0, busy}, 10'b0);

        // Abort in IDLE clears a partial code.
        step(6'b110000);
        step(6'b000100);
        chk("idle_abort", {6'b0, pass_data}, 10'b0);

        // Send with three keys is ignored; fourth key then send starts the session.
        step(6'b110000);
        step(6'b110000);
        step(6'b100000);
        step(6'b001000);
        chk("short_send", {8'b0, request, busy}, 10'b0);
        step(6'b110000);
        chk("fourth_key", {6'b0, pass_data}, {6'b0, 4'b1011});
        step(6'b001000);
        chk("send_req", {8'b0, request, busy}, 10'b11);

        // Abort during CHECK: release next cycle, then idle.
        step(6'b000000);
        step(6'b000000);
        step(6'b000000);
        step(6'b000100);
        chk("abort_release", {4'b0, request, pass_data, busy}, {4'b0, 1'b0, 4'b0000, 1'b1});
        step(6'b000000);
        chk("abort_idle", {4'b0, request, pass_data, busy}, 10'b0);

        // Asynchronous reset in the middle of HOLD.
        enter_code(DEFAULT_PASS);
        to_wait();
        step(6'b000010);
        chk("hold_grant", outs(), o(1, 0, DEFAULT_PASS, 1, 1, 0, 0));
        step(6'b000000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {2'b0, request, granted, pass_data, busy, side}, 10'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enter_code(4'b0011);
        chk("post_reset_code", {5'b0, pass_data, busy}, {5'b0, 4'b0011, 1'b0});
        step(6'b001000);
        chk("post_reset_req", {8'b0, request, busy}, 10'b11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
